angle_profile_ctrl: RTL and testbench
=====================================

# angle_profile_ctrl

Parametrised next-generation angle-to-PWM controller for the swerve steering motors. It converts a target/current encoder angle pair into a stepped PWM ratio stream: accelerate through a profile table, cruise, then decelerate and shut down. It sits between the register file (targets, profile, tuning) and the PWM generator, using the same `pwm_update`/`pwm_done` handshake. Beyond the previous block, it adds:
- a built-in shortest-path delta calculation;
- saturating profile offsets;
- early deceleration from ACCEL;
- abort handling;
- overshoot detection;
- bounded stall retry.

## Interface
- `ANGLE_W`, 12: encoder angle width (one rotation = 2^ANGLE_W counts).
- `PWM_W`, 8: PWM ratio width.
- `STEPS`, 16: profile table depth (power of 2, 4..64).
- `DELAY_W`, 24: profile delay counter width.
- `TOL`, 5: on-target tolerance in counts.
- `STALL_MIN`, 3: minimum movement per profile interval before a stall is flagged.
- `MAX_RETRY`, 2: stall retries before giving up (0..3).

Ports (name, direction, width, meaning):
- `clock` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `pwm_enable` in 1: global enable; low forces IDLE.
- `angle_update` in 1: request a move to `target_angle`; latched when sampled in IDLE.
- `abort` in 1: abandon the current move.
- `target_angle` in ANGLE_W: requested angle.
- `current_angle` in ANGLE_W: encoder angle.
- `pwm_done` in 1: PWM generator has applied the ratio; only rising edges count.
- `enable_stall_chk` in 1: enables stall handling.
- `delay_target` in 8: profile interval = {`delay_target[7:4]`} << `delay_target[3:0]`, truncated to DELAY_W.
- `profile_offset` in PWM_W: added to every profile entry, saturating at 2^PWM_W-1.
- `cruise_power` in PWM_W: ratio during CRUISE.
- `decel_angle` in ANGLE_W: remaining distance at which deceleration begins.
- `pwm_profile` in STEPS*PWM_W: entry i = `pwm_profile[i*PWM_W +: PWM_W]`.
- `pwm_update` out 1: ratio valid/update request to the PWM generator.
- `pwm_ratio` out PWM_W: PWM high time.
- `pwm_direction` out 1: motor direction; 1 = increasing angle.
- `angle_done` out 1: move completed.
- `startup_fail` out 1: stalled during ACCEL with retries exhausted.
- `run_stall` out 1: stalled during CRUISE with retries exhausted.
- `retry_count` out 2: retries used on the current move.
- `state` out 3: FSM state for debug.

## Operation
- **Delta calculation**, registered every cycle:
  - d = (`target_latched` − `current_angle`) mod 2^ANGLE_W.
  - If d ≤ 2^(ANGLE_W−1): dir = 1, dist = d. Otherwise dir = 0, dist = 2^ANGLE_W − d.
- **States:** IDLE=0, CALC=1, ACCEL=2, CRUISE=3, DECEL=4, SHUTDOWN=5, RETRY=6.
- **Transition priority** (highest first): `pwm_enable` low → IDLE; `abort` → SHUTDOWN (aborted); stall handling; distance transitions.
- **IDLE:**
  - Outputs: ratio 0, `pwm_update` 0, step 0.
  - On `angle_update`: latch target; clear `angle_done`, `startup_fail`, `run_stall` and `retry_count`; go to CALC.
- **CALC:** wait one cycle for a valid delta, then latch `pwm_direction` = dir.
  - If dist ≤ TOL → SHUTDOWN.
  - Otherwise → ACCEL with step 0.
- **Profile interval:** `profile_delay` counts `pwm_done` rising edges. When it equals the interval target, it is cleared, a step event fires and `current_angle` is snapshotted. A step therefore lasts target+1 edges.
- **ACCEL:**
  - ratio = sat(profile[step] + offset).
  - Each step event increments step; after step STEPS−1 → CRUISE.
  - If dist < `decel_angle` → DECEL, keeping the current step.
- **CRUISE:** ratio = `cruise_power`; if dist < `decel_angle` → DECEL.
- **DECEL:**
  - ratio = sat(profile[step] + offset).
  - Each step event decrements step, holding at 0.
  - dist ≤ TOL → SHUTDOWN.
  - dir ≠ `pwm_direction` with dist > TOL (overshoot) → SHUTDOWN.
- **Stall check:** applies at step events in ACCEL/CRUISE when `enable_stall_chk` = 1. A stall is flagged if the shortest-path movement since the previous snapshot is < STALL_MIN.
  - If `retry_count` < MAX_RETRY: increment `retry_count`, go to RETRY.
  - Otherwise: set `startup_fail` (ACCEL) or `run_stall` (CRUISE), go to IDLE.
  - The first step event after entering ACCEL only takes a snapshot; it performs no check.
- **RETRY:** ratio 0, `pwm_update` 1; after one full profile interval → CALC (direction recomputed).
- **SHUTDOWN:**
  - ratio 0.
  - `angle_done` set unless aborted.
  - On the next `pwm_done` rising edge → IDLE.
- **Sticky flags:** `angle_done`, `startup_fail` and `run_stall` hold until the next accepted `angle_update` or reset.

## Timing
- **Reset values:**
  - All outputs 0; `state` = IDLE.
  - Counters, step and latched target 0.
- **Startup latency:** `angle_update` high at edge N → CALC after N; ACCEL (or SHUTDOWN) after N+2. `pwm_ratio` shows profile[0] after N+3.
- **Ratio and handshake:** `pwm_ratio` is registered and changes only on state or step change. `pwm_update` is high in ACCEL, CRUISE, DECEL, SHUTDOWN and RETRY.
- **`pwm_done` edge detection:** registered, so a rising edge is acted on 2 cycles after it appears.
- **Response latency:** `abort` and `pwm_enable` drops act on the next clock edge.
- **Wrap-around:** the delta is correct across 0/2^ANGLE_W, e.g. target 4090, current 10 → dir 0, dist 16.

## Test plan
- **Short move:** profile entries 0..15 = 10,20,…,160, offset 0, interval 1, target 100 from 0, `decel_angle` 40 → ACCEL ratios 10,20,… each held 2 `pwm_done` edges; DECEL when dist < 40; `angle_done` = 1 with dist ≤ 5.
- **Wrap:** current 4090, target 20 → `pwm_direction` = 1, dist 26; same move reached across 0.
- **Saturation:** entry 250, offset 20 → `pwm_ratio` = 255.
- **Stall with retry:** `current_angle` frozen, stall check on, MAX_RETRY 2 → two RETRY visits with ratio 0, then `startup_fail` = 1, `retry_count` = 2, IDLE.
- **Abort:** `abort` in CRUISE → SHUTDOWN next cycle, ratio 0, `angle_done` stays 0.
- **Reset mid-move:** assert `reset` in DECEL → all outputs 0 immediately (asynchronous); the next `angle_update` runs normally.

Source files
------------

// File: rtl/angle_profile_ctrl_if.sv
// Register-file and PWM-generator side signals of the angle profile controller.
// master = register file / PWM generator, slave = controller.
interface angle_profile_ctrl_if #(
    parameter int ANGLE_W = 12,
    parameter int PWM_W   = 8,
    parameter int STEPS   = 16
);
    logic                     pwm_enable;
    logic                     angle_update;
    logic                     abort;
    logic [ANGLE_W-1:0]       target_angle;
    logic [ANGLE_W-1:0]       current_angle;
    logic                     pwm_done;
    logic                     enable_stall_chk;
    logic [7:0]               delay_target;
    logic [PWM_W-1:0]         profile_offset;
    logic [PWM_W-1:0]         cruise_power;
    logic [ANGLE_W-1:0]       decel_angle;
    logic [STEPS*PWM_W-1:0]   pwm_profile;

    logic                     pwm_update;
    logic [PWM_W-1:0]         pwm_ratio;
    logic                     pwm_direction;
    logic                     angle_done;
    logic                     startup_fail;
    logic                     run_stall;
    logic [1:0]               retry_count;
    logic [2:0]               state;

    modport master (
        output pwm_enable, angle_update, abort, target_angle, current_angle, pwm_done,
               enable_stall_chk, delay_target, profile_offset, cruise_power, decel_angle,
               pwm_profile,
        input  pwm_update, pwm_ratio, pwm_direction, angle_done, startup_fail, run_stall,
               retry_count, state
    );

    modport slave (
        input  pwm_enable, angle_update, abort, target_angle, current_angle, pwm_done,
               enable_stall_chk, delay_target, profile_offset, cruise_power, decel_angle,
               pwm_profile,
        output pwm_update, pwm_ratio, pwm_direction, angle_done, startup_fail, run_stall,
               retry_count, state
    );
endinterface

// File: rtl/angle_profile_ctrl.sv
// Angle-to-PWM profile controller: shortest-path delta, accel/cruise/decel stepping, stall retry.
// Ratio trails state/step by one cycle; pacing is set by pwm_done rising edges, which act 2 cycles later.
module angle_profile_ctrl #(
    parameter int ANGLE_W   = 12,
    parameter int PWM_W     = 8,
    parameter int STEPS     = 16,
    parameter int DELAY_W   = 24,
    parameter int TOL       = 5,
    parameter int STALL_MIN = 3,
    parameter int MAX_RETRY = 2
) (
    input  logic                clock,
    input  logic                reset,
    angle_profile_ctrl_if.slave bus
);
    localparam int                 SW        = $clog2(STEPS);
    localparam logic [ANGLE_W-1:0] HALF      = ANGLE_W'(1) << (ANGLE_W - 1);
    localparam logic [ANGLE_W-1:0] TOL_V     = ANGLE_W'(TOL);
    localparam logic [ANGLE_W-1:0] STALL_V   = ANGLE_W'(STALL_MIN);
    localparam logic [1:0]         MAX_R     = 2'(MAX_RETRY);
    localparam logic [SW-1:0]      STEP_LAST = SW'(STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CALC   = 3'd1,
        S_ACCEL  = 3'd2,
        S_CRUISE = 3'd3,
        S_DECEL  = 3'd4,
        S_SHUT   = 3'd5,
        S_RETRY  = 3'd6
    } state_t;

    state_t             state_q, state_nxt;
    logic [ANGLE_W-1:0] target_q, snap_q, dist_q;
    logic [ANGLE_W-1:0] delta_raw, dist_c, move_raw, move_dist;
    logic               dir_q, dir_c, pwm_dir_q;
    logic               snap_vld_q, calc_wait_q;
    logic               done_q1, done_q2, done_rise, step_evt, stall_hit, count_en;
    logic [DELAY_W-1:0] delay_q, interval;
    logic [SW-1:0]      step_q;
    logic [1:0]         retry_q;
    logic [PWM_W-1:0]   entry, ratio_c, ratio_q;
    logic [PWM_W:0]     sum;
    logic               angle_done_q, startup_fail_q, run_stall_q;
    logic               accept, calc_go, set_done, set_fail, set_run, inc_retry, step_inc, step_dec;

    assign done_rise = done_q1 & ~done_q2;
    assign interval  = DELAY_W'(bus.delay_target[7:4]) << bus.delay_target[3:0];
    assign step_evt  = done_rise && (delay_q == interval);
    assign stall_hit = step_evt && bus.enable_stall_chk && snap_vld_q && (move_dist < STALL_V);

    // Both the move delta and the stall movement use the shorter way round the circle.
    always_comb begin
        delta_raw = target_q - bus.current_angle;
        dir_c     = (delta_raw <= HALF);
        dist_c    = dir_c ? delta_raw : (ANGLE_W'(0) - delta_raw);
        move_raw  = bus.current_angle - snap_q;
        move_dist = (move_raw <= HALF) ? move_raw : (ANGLE_W'(0) - move_raw);
    end

    always_comb begin
        entry   = bus.pwm_profile[int'(step_q) * PWM_W +: PWM_W];
        sum     = {1'b0, entry} + {1'b0, bus.profile_offset};
        ratio_c = '0;
        case (state_q)
            S_ACCEL, S_DECEL: ratio_c = sum[PWM_W] ? '1 : sum[PWM_W-1:0];
            S_CRUISE:         ratio_c = bus.cruise_power;
            default:          ratio_c = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        calc_go   = 1'b0;
        set_done  = 1'b0;
        set_fail  = 1'b0;
        set_run   = 1'b0;
        inc_retry = 1'b0;
        step_inc  = 1'b0;
        step_dec  = 1'b0;
        if (!bus.pwm_enable) begin
            state_nxt = S_IDLE;
        end else if (bus.abort && state_q != S_IDLE && state_q != S_SHUT) begin
            state_nxt = S_SHUT;
        end else begin
            case (state_q)
                S_IDLE: if (bus.angle_update) begin
                    accept    = 1'b1;
                    state_nxt = S_CALC;
                end
                S_CALC: if (calc_wait_q) begin
                    calc_go = 1'b1;
                    if (dist_q <= TOL_V) begin
                        state_nxt = S_SHUT;
                        set_done  = 1'b1;
                    end else begin
                        state_nxt = S_ACCEL;
                    end
                end
                S_ACCEL: begin
                    if (stall_hit) begin
                        if (retry_q < MAX_R) begin
                            inc_retry = 1'b1;
                            state_nxt = S_RETRY;
                        end else begin
                            set_fail  = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    end else if (dist_q < bus.decel_angle) begin
                        state_nxt = S_DECEL;
                    end else if (step_evt) begin
                        if (step_q == STEP_LAST) state_nxt = S_CRUISE;
                        else                     step_inc  = 1'b1;
                    end
                end
                S_CRUISE: begin
                    if (stall_hit) begin
                        if (retry_q < MAX_R) begin
                            inc_retry = 1'b1;
                            state_nxt = S_RETRY;
                        end else begin
                            set_run   = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    end else if (dist_q < bus.decel_angle) begin
                        state_nxt = S_DECEL;
                    end
                end
                // A direction flip means the target was passed: stop rather than reverse.
                S_DECEL: begin
                    if (dist_q <= TOL_V || dir_q != pwm_dir_q) begin
                        state_nxt = S_SHUT;
                        set_done  = 1'b1;
                    end else if (step_evt && step_q != '0) begin
                        step_dec = 1'b1;
                    end
                end
                S_SHUT:  if (done_rise) state_nxt = S_IDLE;
                S_RETRY: if (step_evt)  state_nxt = S_CALC;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign count_en = (state_nxt == S_ACCEL || state_nxt == S_CRUISE ||
                       state_nxt == S_DECEL || state_nxt == S_RETRY) &&
                      !(state_nxt == S_RETRY && state_q != S_RETRY);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_q1        <= 1'b0;
            done_q2        <= 1'b0;
            target_q       <= '0;
            dir_q          <= 1'b0;
            dist_q         <= '0;
            pwm_dir_q      <= 1'b0;
            calc_wait_q    <= 1'b0;
            snap_q         <= '0;
            snap_vld_q     <= 1'b0;
            delay_q        <= '0;
            step_q         <= '0;
            retry_q        <= '0;
            ratio_q        <= '0;
            angle_done_q   <= 1'b0;
            startup_fail_q <= 1'b0;
            run_stall_q    <= 1'b0;
        end else begin
            done_q1     <= bus.pwm_done;
            done_q2     <= done_q1;
            dir_q       <= dir_c;
            dist_q      <= dist_c;
            ratio_q     <= ratio_c;
            calc_wait_q <= (state_q == S_CALC) && (state_nxt == S_CALC);
            if (accept) begin
                target_q       <= bus.target_angle;
                angle_done_q   <= 1'b0;
                startup_fail_q <= 1'b0;
                run_stall_q    <= 1'b0;
                retry_q        <= '0;
            end
            if (calc_go) begin
                pwm_dir_q  <= dir_q;
                snap_vld_q <= 1'b0;
            end
            // The first step event of a run only seeds the snapshot; later ones are checked against it.
            if ((state_q == S_ACCEL || state_q == S_CRUISE) && step_evt) begin
                snap_q     <= bus.current_angle;
                snap_vld_q <= 1'b1;
            end
            if (!count_en)      delay_q <= '0;
            else if (done_rise) delay_q <= (delay_q == interval) ? '0 : delay_q + DELAY_W'(1);
            if (state_nxt == S_IDLE || calc_go) step_q <= '0;
            else if (step_inc)                  step_q <= step_q + SW'(1);
            else if (step_dec)                  step_q <= step_q - SW'(1);
            if (inc_retry) retry_q        <= retry_q + 2'd1;
            if (set_done)  angle_done_q   <= 1'b1;
            if (set_fail)  startup_fail_q <= 1'b1;
            if (set_run)   run_stall_q    <= 1'b1;
        end
    end

    assign bus.pwm_ratio     = ratio_q;
    assign bus.pwm_update    = (state_q == S_ACCEL || state_q == S_CRUISE || state_q == S_DECEL ||
                                state_q == S_SHUT  || state_q == S_RETRY);
    assign bus.pwm_direction = pwm_dir_q;
    assign bus.angle_done    = angle_done_q;
    assign bus.startup_fail  = startup_fail_q;
    assign bus.run_stall     = run_stall_q;
    assign bus.retry_count   = retry_q;
    assign bus.state         = state_q;
endmodule

// File: tb/tb_angle_profile_ctrl.sv
// Directed-plus-random bench for angle_profile_ctrl against a shortest-path / saturating-profile model.
module tb_angle_profile_ctrl;
    localparam int AW        = 12;
    localparam int PW        = 8;
    localparam int NS        = 16;
    localparam int ROT       = 1 << AW;
    localparam int TOL       = 5;
    localparam int MAX_RETRY = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   prof[NS];
    int   offset;
    int   cruise;
    int   edges;
    int   visits;
    int   prev_state;
    int   c_ang;
    int   t_ang;

    angle_profile_ctrl_if #(.ANGLE_W(AW), .PWM_W(PW), .STEPS(NS)) bus ();

    angle_profile_ctrl #(
        .ANGLE_W(AW), .PWM_W(PW), .STEPS(NS), .DELAY_W(24),
        .TOL(TOL), .STALL_MIN(3), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    function automatic int wrap_d(input int t, input int c);
        return ((t - c) % ROT + ROT) % ROT;
    endfunction
    function automatic int sp_dir(input int t, input int c);
        return (wrap_d(t, c) <= ROT / 2) ? 1 : 0;
    endfunction
    function automatic int sp_dist(input int t, input int c);
        int d;
        d = wrap_d(t, c);
        return (d <= ROT / 2) ? d : ROT - d;
    endfunction
    function automatic int sat(input int a, input int b);
        return (a + b > (1 << PW) - 1) ? (1 << PW) - 1 : a + b;
    endfunction
    function automatic int exp_ratio(input int step);
        return sat(prof[step], offset);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, want);
        end
    endtask

    task automatic load_profile();
        for (int i = 0; i < NS; i++) bus.pwm_profile[i*PW +: PW] = PW'(prof[i]);
        bus.profile_offset = PW'(offset);
        bus.cruise_power   = PW'(cruise);
    endtask

    task automatic pulse();
        bus.pwm_done = 1'b1;
        cyc(1);
        bus.pwm_done = 1'b0;
        cyc(3);
    endtask

    task automatic start_move(input int t);
        bus.target_angle = AW'(t);
        bus.angle_update = 1'b1;
        cyc(1);
        bus.angle_update = 1'b0;
    endtask

    initial begin
        bus.pwm_enable       = 1'b0;
        bus.angle_update     = 1'b0;
        bus.abort            = 1'b0;
        bus.target_angle     = '0;
        bus.current_angle    = '0;
        bus.pwm_done         = 1'b0;
        bus.enable_stall_chk = 1'b0;
        bus.delay_target     = 8'h10;
        bus.decel_angle      = AW'(40);
        bus.pwm_profile      = '0;
        bus.profile_offset   = '0;
        bus.cruise_power     = '0;
        cyc(2);
        chk("rst_state",  bus.state,      0);
        chk("rst_ratio",  bus.pwm_ratio,  0);
        chk("rst_update", bus.pwm_update, 0);
        chk("rst_done",   bus.angle_done, 0);
        chk("rst_retry",  bus.retry_count, 0);
        reset = 1'b0;
        bus.pwm_enable = 1'b1;
        cyc(1);

        // Short move: 10,20,..,160, interval 1, 0 -> 100.
        for (int i = 0; i < NS; i++) prof[i] = 10 * (i + 1);
        offset = 0;
        cruise = 200;
        load_profile();
        start_move(100);
        chk("calc_state", bus.state, 1);
        cyc(2);
        chk("accel_state", bus.state, (sp_dist(100, 0) > TOL) ? 2 : 5);
        chk("accel_dir",   bus.pwm_direction, sp_dir(100, 0));
        cyc(1);
        chk("accel_r0",    bus.pwm_ratio, exp_ratio(0));
        chk("accel_upd",   bus.pwm_update, 1);
        edges = 0;
        for (int k = 0; k < 6; k++) begin
            pulse();
            edges++;
            chk("accel_step", bus.pwm_ratio, exp_ratio(edges / 2));
        end
        bus.current_angle = AW'(70);
        cyc(3);
        chk("decel_state", bus.state, (sp_dist(100, 70) < 40) ? 4 : 2);
        chk("decel_hold",  bus.pwm_ratio, exp_ratio(edges / 2));
        pulse();
        pulse();
        chk("decel_step",  bus.pwm_ratio, exp_ratio(edges / 2 - 1));
        bus.current_angle = AW'(97);
        cyc(3);
        chk("shut_state",  bus.state, 5);
        chk("shut_done",   bus.angle_done, (sp_dist(100, 97) <= TOL) ? 1 : 0);
        chk("shut_ratio",  bus.pwm_ratio, 0);
        pulse();
        chk("idle_state",  bus.state, 0);
        chk("idle_sticky", bus.angle_done, 1);

        // Wrap across zero, increasing: 4090 -> 20.
        bus.current_angle = AW'(4090);
        start_move(20);
        cyc(2);
        chk("wrap_dir",   bus.pwm_direction, sp_dir(20, 4090));
        cyc(1);
        chk("wrap_decel", bus.state, (sp_dist(20, 4090) < 40) ? 4 : 2);
        bus.current_angle = AW'(19);
        cyc(2);
        chk("wrap_shut",  bus.state, 5);
        chk("wrap_done",  bus.angle_done, 1);
        pulse();

        // Random wrap, decreasing direction, then overshoot past the target.
        c_ang = int'($urandom_range(10, 20));
        t_ang = ROT - int'($urandom_range(5, 15));
        bus.current_angle = AW'(c_ang);
        start_move(t_ang);
        cyc(2);
        chk("rwrap_dir",   bus.pwm_direction, sp_dir(t_ang, c_ang));
        cyc(1);
        chk("rwrap_decel", bus.state, (sp_dist(t_ang, c_ang) < 40) ? 4 : 2);
        c_ang = (t_ang - 10 + ROT) % ROT;
        bus.current_angle = AW'(c_ang);
        cyc(2);
        chk("ovs_state", bus.state, (sp_dir(t_ang, c_ang) == 1 && sp_dist(t_ang, c_ang) > TOL) ? 5 : 4);
        chk("ovs_done",  bus.angle_done, 1);
        pulse();

        // Random profile with saturation, interval 0, through to CRUISE, then abort.
        for (int i = 0; i < NS; i++) prof[i] = int'($urandom_range(0, 255));
        prof[0] = 250;
        offset  = 20;
        cruise  = int'($urandom_range(0, 255));
        load_profile();
        bus.delay_target  = 8'h00;
        bus.current_angle = AW'(0);
        start_move(1000);
        cyc(3);
        chk("sat_r0", bus.pwm_ratio, exp_ratio(0));
        for (int k = 1; k < NS; k++) begin
            pulse();
            chk("prof_step", bus.pwm_ratio, exp_ratio(k));
        end
        pulse();
        chk("cruise_state", bus.state, 3);
        chk("cruise_ratio", bus.pwm_ratio, cruise);
        bus.abort = 1'b1;
        cyc(1);
        bus.abort = 1'b0;
        chk("abort_state", bus.state, 5);
        cyc(1);
        chk("abort_ratio", bus.pwm_ratio, 0);
        chk("abort_done",  bus.angle_done, 0);
        chk("abort_upd",   bus.pwm_update, 1);
        pulse();
        chk("abort_idle",  bus.state, 0);

        // Stall with retries: encoder frozen.
        bus.delay_target     = 8'h10;
        bus.enable_stall_chk = 1'b1;
        start_move(1000);
        visits = 0;
        prev_state = int'(bus.state);
        for (int p = 0; p < 300 && bus.state != 3'd0; p++) begin
            bus.pwm_done = (p % 4 == 0);
            cyc(1);
            if (bus.state == 3'd6 && prev_state != 6) begin
                visits++;
                chk("retry_cnt", bus.retry_count, visits);
            end else if (bus.state == 3'd6) begin
                chk("retry_ratio", bus.pwm_ratio, 0);
                chk("retry_upd",   bus.pwm_update, 1);
            end
            prev_state = int'(bus.state);
        end
        bus.pwm_done = 1'b0;
        chk("stall_visits", visits, MAX_RETRY);
        chk("stall_idle",   bus.state, 0);
        chk("stall_fail",   bus.startup_fail, 1);
        chk("stall_retry",  bus.retry_count, MAX_RETRY);
        chk("stall_run",    bus.run_stall, 0);
        bus.enable_stall_chk = 1'b0;
        cyc(2);

        // Asynchronous reset mid-DECEL, then a normal move.
        bus.delay_target = 8'h00;
        start_move(1000);
        cyc(2);
        bus.current_angle = AW'(980);
        cyc(2);
        chk("pre_rst_state", bus.state, 4);
        reset = 1'b1;
        #1;
        chk("arst_state", bus.state, 0);
        chk("arst_ratio", bus.pwm_ratio, 0);
        chk("arst_upd",   bus.pwm_update, 0);
        chk("arst_dir",   bus.pwm_direction, 0);
        chk("arst_fail",  bus.startup_fail, 0);
        @(negedge clock);
        reset = 1'b0;
        bus.current_angle = AW'(0);
        start_move(3);
        cyc(2);
        chk("post_rst_state", bus.state, (sp_dist(3, 0) <= TOL) ? 5 : 2);
        chk("post_rst_done",  bus.angle_done, 1);
        pulse();

        // Enable drop forces IDLE on the next edge.
        start_move(1000);
        cyc(2);
        chk("en_accel", bus.state, 2);
        bus.pwm_enable = 1'b0;
        cyc(1);
        chk("en_idle", bus.state, 0);
        cyc(1);
        chk("en_ratio", bus.pwm_ratio, 0);
        bus.pwm_enable = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
